// File: rtl/vga_sync_module.sv
// 800x600@60 VGA timing generator: cascaded line/frame counters with registered sync, ready and pixel address decode.
// Define VGA_SYNC_ACTIVE_LOW_EN to drive HSYNC_Sig/VSYNC_Sig active-low.
module vga_sync_module #(
    parameter int H_SYNC   = 128,
    parameter int H_BACK   = 88,
    parameter int H_ACTIVE = 800,
    parameter int H_FRONT  = 40,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 23,
    parameter int V_ACTIVE = 600,
    parameter int V_FRONT  = 1
) (
    input  logic        CLK,
    input  logic        RSTn,
    output logic        HSYNC_Sig,
    output logic        VSYNC_Sig,
    output logic        Ready_Sig,
    output logic [10:0] Column_Addr_Sig,
    output logic [10:0] Row_Addr_Sig
);

    localparam logic [10:0] H_LAST    = 11'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [10:0] V_LAST    = 11'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
    localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
    localparam logic [10:0] H_START   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END     = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] V_START   = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_END     = 11'(V_SYNC + V_BACK + V_ACTIVE);

`ifdef VGA_SYNC_ACTIVE_LOW_EN
    localparam logic SYNC_IDLE = 1'b1;
`else
    localparam logic SYNC_IDLE = 1'b0;
`endif

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_end;
    logic        v_end;
    logic        hsync_on;
    logic        vsync_on;
    logic        ready_c;

    assign h_end    = (h_cnt == H_LAST);
    assign v_end    = (v_cnt == V_LAST);
    assign hsync_on = (h_cnt < H_SYNC_W);
    assign vsync_on = (v_cnt < V_SYNC_W);
    assign ready_c  = (h_cnt >= H_START) && (h_cnt < H_END) &&
                      (v_cnt >= V_START) && (v_cnt < V_END);

    // The frame counter only advances on the last pixel of each line.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_end ? 11'd0 : h_cnt + 11'd1;
            if (h_end) begin
                v_cnt <= v_end ? 11'd0 : v_cnt + 11'd1;
            end
        end
    end

    // Every output shares one register stage so sync, ready and addresses stay aligned.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            HSYNC_Sig       <= SYNC_IDLE;
            VSYNC_Sig       <= SYNC_IDLE;
            Ready_Sig       <= 1'b0;
            Column_Addr_Sig <= '0;
            Row_Addr_Sig    <= '0;
        end else begin
            HSYNC_Sig       <= hsync_on ^ SYNC_IDLE;
            VSYNC_Sig       <= vsync_on ^ SYNC_IDLE;
            Ready_Sig       <= ready_c;
            Column_Addr_Sig <= ready_c ? (h_cnt - H_START) : 11'd0;
            Row_Addr_Sig    <= ready_c ? (v_cnt - V_START) : 11'd0;
        end
    end

endmodule

// File: tb/tb_vga_sync_module.sv
// Directed bench for vga_sync_module: full-size instance for line/first-frame timing and reset,
// plus a miniature instance to exercise frame wrap and window masking within a short run.
module tb_vga_sync_module;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        rst_s_n;
    logic        hsync, vsync, ready;
    logic [10:0] col, row;
    logic        s_hsync, s_vsync, s_ready;
    logic [10:0] s_col, s_row;

    int checks = 0;
    int fails  = 0;
    int edge_n = 0;
    int vs_high = 0;

`ifdef VGA_SYNC_ACTIVE_LOW_EN
    localparam logic SYNC_ON  = 1'b0;
    localparam logic SYNC_OFF = 1'b1;
`else
    localparam logic SYNC_ON  = 1'b1;
    localparam logic SYNC_OFF = 1'b0;
`endif

    always #5 CLK = ~CLK;

    vga_sync_module dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .HSYNC_Sig       (hsync),
        .VSYNC_Sig       (vsync),
        .Ready_Sig       (ready),
        .Column_Addr_Sig (col),
        .Row_Addr_Sig    (row)
    );

    // Tiny raster (17 clocks x 11 lines) so whole frames and wraps fit in a short run.
    vga_sync_module #(
        .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_ACTIVE(5), .V_FRONT(1)
    ) dut_small (
        .CLK             (CLK),
        .RSTn            (rst_s_n),
        .HSYNC_Sig       (s_hsync),
        .VSYNC_Sig       (s_vsync),
        .Ready_Sig       (s_ready),
        .Column_Addr_Sig (s_col),
        .Row_Addr_Sig    (s_row)
    );

    task automatic tick();
        @(posedge CLK);
        #2;
        edge_n++;
        if (vsync === SYNC_ON) vs_high++;
    endtask

    task automatic test_reset();
        RSTn    = 1'b0;
        rst_s_n = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        checks += 5;
        if (hsync !== SYNC_OFF) begin fails++; $display("[TB] FAIL reset_hsync: got %b expected %b", hsync, SYNC_OFF); end
        if (vsync !== SYNC_OFF) begin fails++; $display("[TB] FAIL reset_vsync: got %b expected %b", vsync, SYNC_OFF); end
        if (ready !== 1'b0)     begin fails++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
        if (col !== 11'd0)      begin fails++; $display("[TB] FAIL reset_col: got %0d expected 0", col); end
        if (row !== 11'd0)      begin fails++; $display("[TB] FAIL reset_row: got %0d expected 0", row); end
        checks += 2;
        if (s_hsync !== SYNC_OFF) begin fails++; $display("[TB] FAIL reset_small_hsync: got %b expected %b", s_hsync, SYNC_OFF); end
        if (s_ready !== 1'b0)     begin fails++; $display("[TB] FAIL reset_small_ready: got %b expected 0", s_ready); end
        RSTn    = 1'b1;
        edge_n  = 0;
        vs_high = 0;
        tick();
        checks += 3;
        if (hsync !== SYNC_ON) begin fails++; $display("[TB] FAIL first_edge_hsync: got %b expected %b", hsync, SYNC_ON); end
        if (vsync !== SYNC_ON) begin fails++; $display("[TB] FAIL first_edge_vsync: got %b expected %b", vsync, SYNC_ON); end
        if (ready !== 1'b0)    begin fails++; $display("[TB] FAIL first_edge_ready: got %b expected 0", ready); end
    endtask

    task automatic test_line_timing();
        int   hs_cnt   = (hsync === SYNC_ON) ? 1 : 0;
        int   mask_err = 0;
        logic hs128    = 1'bx;
        logic hs129    = 1'bx;
        while (edge_n < 1056) begin
            tick();
            if (hsync === SYNC_ON) hs_cnt++;
            if (edge_n == 128) hs128 = hsync;
            if (edge_n == 129) hs129 = hsync;
            if (ready !== 1'b1 && (col !== 11'd0 || row !== 11'd0)) mask_err++;
        end
        checks += 4;
        if (hs_cnt != 128)     begin fails++; $display("[TB] FAIL hsync_width: got %0d expected 128", hs_cnt); end
        if (hs128 !== SYNC_ON) begin fails++; $display("[TB] FAIL hsync_last_on: got %b expected %b", hs128, SYNC_ON); end
        if (hs129 !== SYNC_OFF) begin fails++; $display("[TB] FAIL hsync_first_off: got %b expected %b", hs129, SYNC_OFF); end
        if (mask_err != 0)     begin fails++; $display("[TB] FAIL line0_mask: got %0d errors expected 0", mask_err); end
        tick();
        checks++;
        if (hsync !== SYNC_ON) begin fails++; $display("[TB] FAIL hsync_period: got %b at edge 1057 expected %b", hsync, SYNC_ON); end
    endtask

    task automatic test_frame_start(input string tag);
        int   first_ready = 0;
        int   mask_err    = 0;
        logic vs4224      = 1'bx;
        logic vs4225      = 1'bx;
        while (edge_n < 28729) begin
            tick();
            if (ready === 1'b1 && first_ready == 0) first_ready = edge_n;
            if (edge_n == 4224) vs4224 = vsync;
            if (edge_n == 4225) vs4225 = vsync;
            if (ready !== 1'b1 && (col !== 11'd0 || row !== 11'd0)) mask_err++;
        end
        checks += 7;
        if (first_ready != 28729) begin fails++; $display("[TB] FAIL %s_first_ready_edge: got %0d expected 28729", tag, first_ready); end
        if (col !== 11'd0)        begin fails++; $display("[TB] FAIL %s_first_col: got %0d expected 0", tag, col); end
        if (row !== 11'd0)        begin fails++; $display("[TB] FAIL %s_first_row: got %0d expected 0", tag, row); end
        if (vs_high != 4224)      begin fails++; $display("[TB] FAIL %s_vsync_width: got %0d expected 4224", tag, vs_high); end
        if (vs4224 !== SYNC_ON)   begin fails++; $display("[TB] FAIL %s_vsync_last_on: got %b expected %b", tag, vs4224, SYNC_ON); end
        if (vs4225 !== SYNC_OFF)  begin fails++; $display("[TB] FAIL %s_vsync_first_off: got %b expected %b", tag, vs4225, SYNC_OFF); end
        if (mask_err != 0)        begin fails++; $display("[TB] FAIL %s_porch_mask: got %0d errors expected 0", tag, mask_err); end
    endtask

    task automatic test_active_line();
        int         rdy_cnt = (ready === 1'b1) ? 1 : 0;
        int         col_err = 0;
        int         row_err = 0;
        int         mask_err = 0;
        logic [10:0] col799 = 11'h7ff;
        logic        rdy_after = 1'bx;
        while (edge_n < 28729 + 1055) begin
            tick();
            if (ready === 1'b1) begin
                rdy_cnt++;
                if (col !== 11'(edge_n - 28729)) col_err++;
                if (row !== 11'd0) row_err++;
            end else if (col !== 11'd0 || row !== 11'd0) begin
                mask_err++;
            end
            if (edge_n == 28729 + 799) col799 = col;
            if (edge_n == 28729 + 800) rdy_after = ready;
        end
        checks += 6;
        if (rdy_cnt != 800)      begin fails++; $display("[TB] FAIL ready_width: got %0d expected 800", rdy_cnt); end
        if (col_err != 0)        begin fails++; $display("[TB] FAIL col_steps: got %0d errors expected 0", col_err); end
        if (row_err != 0)        begin fails++; $display("[TB] FAIL row_constant: got %0d errors expected 0", row_err); end
        if (col799 !== 11'd799)  begin fails++; $display("[TB] FAIL last_col: got %0d expected 799", col799); end
        if (rdy_after !== 1'b0)  begin fails++; $display("[TB] FAIL ready_after_line: got %b expected 0", rdy_after); end
        if (mask_err != 0)       begin fails++; $display("[TB] FAIL front_porch_mask: got %0d errors expected 0", mask_err); end
        tick();
        checks += 3;
        if (ready !== 1'b1)  begin fails++; $display("[TB] FAIL line1_ready: got %b expected 1", ready); end
        if (row !== 11'd1)   begin fails++; $display("[TB] FAIL line1_row: got %0d expected 1", row); end
        if (col !== 11'd0)   begin fails++; $display("[TB] FAIL line1_col: got %0d expected 0", col); end
    endtask

    task automatic test_midframe_reset();
        while (edge_n < 28729 + 2 * 1056 + 400) tick();
        checks += 3;
        if (ready !== 1'b1)   begin fails++; $display("[TB] FAIL mid_ready: got %b expected 1", ready); end
        if (col !== 11'd400)  begin fails++; $display("[TB] FAIL mid_col: got %0d expected 400", col); end
        if (row !== 11'd2)    begin fails++; $display("[TB] FAIL mid_row: got %0d expected 2", row); end
        #1;
        RSTn = 1'b0;
        #1;
        checks += 5;
        if (hsync !== SYNC_OFF) begin fails++; $display("[TB] FAIL async_hsync: got %b expected %b", hsync, SYNC_OFF); end
        if (vsync !== SYNC_OFF) begin fails++; $display("[TB] FAIL async_vsync: got %b expected %b", vsync, SYNC_OFF); end
        if (ready !== 1'b0)     begin fails++; $display("[TB] FAIL async_ready: got %b expected 0", ready); end
        if (col !== 11'd0)      begin fails++; $display("[TB] FAIL async_col: got %0d expected 0", col); end
        if (row !== 11'd0)      begin fails++; $display("[TB] FAIL async_row: got %0d expected 0", row); end
        repeat (2) @(posedge CLK);
        #2;
        RSTn    = 1'b1;
        edge_n  = 0;
        vs_high = 0;
        tick();
        checks += 2;
        if (hsync !== SYNC_ON) begin fails++; $display("[TB] FAIL restart_hsync: got %b expected %b", hsync, SYNC_ON); end
        if (vsync !== SYNC_ON) begin fails++; $display("[TB] FAIL restart_vsync: got %b expected %b", vsync, SYNC_ON); end
        test_frame_start("restart");
    endtask

    task automatic test_small_frame();
        int k, h, v;
        logic        e_hs, e_vs, e_rdy;
        logic [10:0] e_col, e_row;
        @(posedge CLK);
        #2;
        rst_s_n = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge CLK);
            #2;
            k = n - 1;
            h = k % 17;
            v = (k / 17) % 11;
            e_hs  = (h < 4) ? SYNC_ON : SYNC_OFF;
            e_vs  = (v < 2) ? SYNC_ON : SYNC_OFF;
            e_rdy = (h >= 7 && h < 15 && v >= 5 && v < 10);
            e_col = e_rdy ? 11'(h - 7) : 11'd0;
            e_row = e_rdy ? 11'(v - 5) : 11'd0;
            checks += 5;
            if (s_hsync !== e_hs)  begin fails++; $display("[TB] FAIL small_hsync edge %0d: got %b expected %b", n, s_hsync, e_hs); end
            if (s_vsync !== e_vs)  begin fails++; $display("[TB] FAIL small_vsync edge %0d: got %b expected %b", n, s_vsync, e_vs); end
            if (s_ready !== e_rdy) begin fails++; $display("[TB] FAIL small_ready edge %0d: got %b expected %b", n, s_ready, e_rdy); end
            if (s_col !== e_col)   begin fails++; $display("[TB] FAIL small_col edge %0d: got %0d expected %0d", n, s_col, e_col); end
            if (s_row !== e_row)   begin fails++; $display("[TB] FAIL small_row edge %0d: got %0d expected %0d", n, s_row, e_row); end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_start("frame0");
        test_active_line();
        test_midframe_reset();
        test_small_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
